// File: rtl/tick_period_meter.sv
// Measures the cycle count between successive tick events and reports it with a valid pulse, lock and overflow flags.
// Optional macro TICK_PERIOD_EDGE_EN: treat tick as a level and count only its rising edges.
module tick_period_meter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, MEASURE, OVFL} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             locked_reg, locked_next;
  logic             ovf_reg, ovf_next;
  logic             event_w;

`ifdef TICK_PERIOD_EDGE_EN
  logic tick_q_reg;

  // Cleared while disabled so a level already high at re-enable counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst || !enable) tick_q_reg <= 1'b0;
    else                tick_q_reg <= tick;
  end

  assign event_w = tick & ~tick_q_reg;
`else
  assign event_w = tick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      prev_reg   <= '0;
      period_reg <= '0;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      prev_reg   <= prev_next;
      period_reg <= period_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    prev_next   = prev_reg;
    period_next = period_reg;
    valid_next  = 1'b0;
    locked_next = locked_reg;
    ovf_next    = ovf_reg;

    if (!enable) begin
      state_next  = IDLE;
      cnt_next    = '0;
      locked_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (event_w) begin
            cnt_next   = CNT_ONE;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          // A closing event wins over saturation, so a gap of exactly all-ones is still reported.
          if (event_w) begin
            period_next = cnt_reg;
            valid_next  = 1'b1;
            ovf_next    = 1'b0;
            prev_next   = cnt_reg;
            locked_next = (cnt_reg == prev_reg) && (prev_reg != '0);
            cnt_next    = CNT_ONE;
          end else if (cnt_reg == CNT_MAX) begin
            state_next  = OVFL;
            ovf_next    = 1'b1;
            locked_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        OVFL: begin
          // Resynchronise: the overlong gap is dropped and lock history restarts.
          if (event_w) begin
            cnt_next   = CNT_ONE;
            prev_next  = '0;
            state_next = MEASURE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign locked       = locked_reg;
  assign overflow     = ovf_reg;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a per-cycle vector table on a 32-bit instance plus
// hand-written sequences for tick-held, level-tick and 4-bit overflow cases.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_tick;
  logic [31:0] a_period;
  logic        a_valid, a_locked, a_ovf;

  logic        b_rst, b_en, b_tick;
  logic [3:0]  b_period;
  logic        b_valid, b_locked, b_ovf;

  tick_period_meter #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .tick(a_tick),
    .period(a_period), .period_valid(a_valid), .locked(a_locked), .overflow(a_ovf)
  );

  tick_period_meter #(.WIDTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .tick(b_tick),
    .period(b_period), .period_valid(b_valid), .locked(b_locked), .overflow(b_ovf)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        tick;
    logic [31:0] period;
    logic        valid;
    logic        locked;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic e, input logic t,
                     input logic [31:0] p, input logic v, input logic l, input logic o);
    vec_t x;
    x.rst = r; x.en = e; x.tick = t; x.period = p; x.valid = v; x.locked = l; x.ovf = o;
    vecs.push_back(x);
  endtask

  // n idle (enabled, no tick) cycles with unchanged expected outputs
  task automatic add_quiet(input int n, input logic [31:0] p, input logic l);
    for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, p, 1'b0, l, 1'b0);
  endtask

  task automatic step_a(input logic r, input logic e, input logic t);
    a_rst = r; a_en = e; a_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, input logic e, input logic t);
    b_rst = r; b_en = e; b_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [31:0] p, input logic v,
                       input logic l, input logic o);
    total++;
    if ({a_period, a_valid, a_locked, a_ovf} !== {p, v, l, o}) begin
      bad++;
      $display("FAIL %s: got period=%0d valid=%b locked=%b ovf=%b, want period=%0d valid=%b locked=%b ovf=%b",
               name, a_period, a_valid, a_locked, a_ovf, p, v, l, o);
    end else begin
      $display("ok   %s: period=%0d valid=%b locked=%b ovf=%b", name, a_period, a_valid, a_locked, a_ovf);
    end
  endtask

  task automatic chk_b(input string name, input logic [3:0] p, input logic v,
                       input logic l, input logic o);
    total++;
    if ({b_period, b_valid, b_locked, b_ovf} !== {p, v, l, o}) begin
      bad++;
      $display("FAIL %s: got period=%0d valid=%b locked=%b ovf=%b, want period=%0d valid=%b locked=%b ovf=%b",
               name, b_period, b_valid, b_locked, b_ovf, p, v, l, o);
    end else begin
      $display("ok   %s: period=%0d valid=%b locked=%b ovf=%b", name, b_period, b_valid, b_locked, b_ovf);
    end
  endtask

  initial begin
    logic [31:0] last_p;
    logic        exp_v;

    // ---- vector table for dut_a: one row per clock, expected outputs after that edge ----
    add(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);           // reset
    add_quiet(1, 0, 0);
    add(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);           // first event: no valid
    add_quiet(3, 0, 0);
    add(1'b0, 1'b1, 1'b1, 4, 1, 0, 0);           // gap 4, no history yet
    add_quiet(3, 4, 0);
    add(1'b0, 1'b1, 1'b1, 4, 1, 1, 0);           // second 4: locked
    add_quiet(3, 4, 1);
    add(1'b0, 1'b1, 1'b1, 4, 1, 1, 0);           // steady cmp=4 train
    add_quiet(5, 4, 1);
    add(1'b0, 1'b1, 1'b1, 6, 1, 0, 0);           // gap 6 breaks lock
    add_quiet(5, 6, 0);
    add(1'b0, 1'b1, 1'b1, 6, 1, 1, 0);           // second 6 relocks
    add_quiet(2, 6, 1);
    add(1'b0, 1'b0, 1'b0, 6, 0, 0, 0);           // enable dropped mid-gap
    add(1'b0, 1'b1, 1'b1, 6, 0, 0, 0);           // restart: no valid
    add_quiet(2, 6, 0);
    add(1'b0, 1'b1, 1'b1, 3, 1, 0, 0);           // fresh measurement, 3 != 6
    add_quiet(2, 3, 0);
    add(1'b0, 1'b1, 1'b1, 3, 1, 1, 0);
    add_quiet(1, 3, 1);
    add(1'b0, 1'b0, 1'b1, 3, 0, 0, 0);           // disable coincident with tick
    add(1'b0, 1'b1, 1'b0, 3, 0, 0, 0);
    add(1'b0, 1'b1, 1'b1, 3, 0, 0, 0);           // first event after re-enable
    add_quiet(1, 3, 0);
    add(1'b0, 1'b1, 1'b1, 2, 1, 0, 0);
    add_quiet(1, 2, 0);
    add(1'b0, 1'b1, 1'b1, 2, 1, 1, 0);
    add_quiet(1, 2, 1);
    add(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);           // reset mid-measure clears everything
    add(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    add_quiet(1, 0, 0);
    add(1'b0, 1'b1, 1'b1, 2, 1, 0, 0);           // prev cleared by reset: no lock

    a_rst = 1'b1; a_en = 1'b0; a_tick = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_tick = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].rst, vecs[i].en, vecs[i].tick);
      chk_a($sformatf("vec%0d", i), vecs[i].period, vecs[i].valid, vecs[i].locked, vecs[i].ovf);
    end

    // ---- tick held high every cycle ----
    step_a(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b1, 1'b1);
`ifdef TICK_PERIOD_EDGE_EN
      chk_a($sformatf("held%0d", i), 0, 1'b0, 1'b0, 1'b0);
`else
      if (i == 0)      chk_a($sformatf("held%0d", i), 0, 1'b0, 1'b0, 1'b0);
      else if (i == 1) chk_a($sformatf("held%0d", i), 1, 1'b1, 1'b0, 1'b0);
      else             chk_a($sformatf("held%0d", i), 1, 1'b1, 1'b1, 1'b0);
`endif
    end

    // ---- tick high for 3 cycles out of every 10 ----
    step_a(1'b1, 1'b0, 1'b0);
    last_p = 0;
    for (int i = 0; i < 30; i++) begin
      logic t;
      t = ((i % 10) < 3);
      step_a(1'b0, 1'b1, t);
`ifdef TICK_PERIOD_EDGE_EN
      exp_v = (i > 0) && ((i % 10) == 0);
      if (exp_v) last_p = 10;
`else
      exp_v = (i > 0) && t;
      if (exp_v) last_p = ((i % 10) == 0) ? 32'd8 : 32'd1;
`endif
      total++;
      if ({a_period, a_valid} !== {last_p, exp_v}) begin
        bad++;
        $display("FAIL lvl%0d: got period=%0d valid=%b, want period=%0d valid=%b",
                 i, a_period, a_valid, last_p, exp_v);
      end else begin
        $display("ok   lvl%0d: period=%0d valid=%b", i, a_period, a_valid);
      end
    end
    step_a(1'b0, 1'b0, 1'b0);

    // ---- 4-bit instance: max period and overflow ----
    step_b(1'b1, 1'b0, 1'b0);
    chk_b("b_reset", 0, 1'b0, 1'b0, 1'b0);
    step_b(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step_b(1'b0, 1'b1, 1'b0);
    chk_b("b_gap15_pre", 0, 1'b0, 1'b0, 1'b0);
    step_b(1'b0, 1'b1, 1'b1);
    chk_b("b_gap15", 15, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step_b(1'b0, 1'b1, 1'b0);
      if (i == 13) chk_b("b_sat_edge", 15, 1'b0, 1'b0, 1'b0);
    end
    chk_b("b_ovf_set", 15, 1'b0, 1'b0, 1'b1);
    step_b(1'b0, 1'b1, 1'b1);
    chk_b("b_resync", 15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step_b(1'b0, 1'b1, 1'b0);
    step_b(1'b0, 1'b1, 1'b1);
    chk_b("b_gap5a", 5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step_b(1'b0, 1'b1, 1'b0);
    step_b(1'b0, 1'b1, 1'b1);
    chk_b("b_gap5b", 5, 1'b1, 1'b1, 1'b0);
    step_b(1'b1, 1'b1, 1'b0);
    chk_b("b_reset2", 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
